time_of_day_counter: RTL and testbench
======================================

// Module: time_of_day_counter
// PURPOSE
//  Free-running 24-hour time-of-day counter: divides the system clock to a 1 Hz tick
//  and maintains hours/minutes/seconds. Feeds the running time into the clock-control
//  FSM's hours/minutes/seconds inputs.
//  Consumes that FSM's update pulse and set values to load a new time.
//  Emits tick and minute strobes used by the dose scheduler downstream.
// PARAMETERS
//  CLK_FREQ   50000000  system clock cycles per second; prescaler terminal count = CLK_FREQ-1
//  PRE_W      26        prescaler width; must satisfy 2**PRE_W >= CLK_FREQ
// PORTS
//  clock        in   1  system clock, all state on rising edge
//  reset        in   1  asynchronous, active-low; 0 clears all state immediately
//  update       in   1  load request (level, sampled each cycle); loads set* values
//  hold         in   1  1 = freeze time and prescaler (driven while user is setting time)
//  setHours     in   5  load value, hours, valid 0..23
//  setMinutes   in   6  load value, minutes, valid 0..59
//  setSeconds   in   6  load value, seconds, valid 0..59
//  hours        out  5  current hours 0..23, registered
//  minutes      out  6  current minutes 0..59, registered
//  seconds      out  6  current seconds 0..59, registered
//  secondTick   out  1  one-cycle pulse in the cycle seconds advances
//  minuteTick   out  1  one-cycle pulse in the cycle minutes advances (seconds 59->0)
//  dayRollover  out  1  one-cycle pulse when 23:59:59 -> 00:00:00
//  loadError    out  1  sticky; set when a load carried an out-of-range field
// BEHAVIOUR
//  Reset (reset=0, async): hours/minutes/seconds=0, prescaler=0, all strobes=0, loadError=0.
//  Prescaler: counts 0..CLK_FREQ-1 while hold=0 and update=0; terminal count sets tick.
//   At terminal count it wraps to 0.
//  Tick: seconds+1. On 59 it wraps to 0 and minutes+1. Minutes 59 wraps to 0 with hours+1.
//   Hours 23 wraps to 0. All carries occur in the same cycle, so time is never transiently invalid.
//  Strobes are registered. They assert in the same edge the time registers change, for exactly 1 cycle.
//  Load (update=1): priority over tick and hold. Each field is checked independently.
//   An in-range field loads; an out-of-range field loads 0 and sets loadError.
//   Prescaler clears to 0, so the first tick after a load comes a full CLK_FREQ cycles later.
//   No strobes fire on a load cycle, even if the prescaler was at terminal count.
//  update held high for N cycles: reloads every cycle, and the prescaler stays at 0.
//  Hold (hold=1, update=0): time, prescaler and strobes are frozen/0. Counting resumes
//   from the frozen prescaler value when hold drops; no tick is lost or duplicated.
//  loadError clears only on reset.
//  Reset mid-count: outputs drop to 0 asynchronously. Counting restarts from prescaler=0
//   on the first edge after reset releases.
//  Widths: field increments use same-width compare against 59/23; no wider arithmetic.
//  Latency: set* -> outputs 1 cycle after the update edge. Prescaler tick -> outputs same edge.
// TESTING (CLK_FREQ=4 in bench)
//  1. Release reset, run 16 clocks -> seconds=4. secondTick pulses every 4th cycle,
//     1 cycle wide; minuteTick stays 0.
//  2. Load 00:00:58 via update, run 8 clocks -> 00:00:59 then 00:01:00.
//     minuteTick and secondTick coincide on the second tick.
//  3. Load 23:59:59, run 4 clocks -> 00:00:00. secondTick, minuteTick and dayRollover
//     all pulse together.
//  4. Load 25:61:10 -> hours=0, minutes=0, seconds=10, loadError=1.
//     A following valid load leaves loadError=1.
//  5. Prescaler at 2, hold=1 for 10 cycles -> time unchanged, no strobes.
//     Release -> secondTick 2 cycles later.
//  6. Assert update on the prescaler terminal cycle -> set values appear with no strobe.
//     Next tick 4 cycles later. Pulse reset low mid-count -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour hh:mm:ss counter driven by a 1 Hz prescaler, with load, hold and tick strobes
module time_of_day_counter #(
  parameter int CLK_FREQ = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       update,
  input  logic       hold,
  input  logic [4:0] setHours,
  input  logic [5:0] setMinutes,
  input  logic [5:0] setSeconds,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       secondTick,
  output logic       minuteTick,
  output logic       dayRollover,
  output logic       loadError
);
  logic [PRE_W-1:0] prescaler;
  logic tick, sec_wrap, min_wrap, hr_wrap;
  logic hours_bad, minutes_bad, seconds_bad;
  assign tick        = prescaler == PRE_W'(CLK_FREQ - 1);
  assign sec_wrap    = seconds == 6'd59;
  assign min_wrap    = minutes == 6'd59;
  assign hr_wrap     = hours == 5'd23;
  assign hours_bad   = setHours > 5'd23;
  assign minutes_bad = setMinutes > 6'd59;
  assign seconds_bad = setSeconds > 6'd59;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prescaler   <= '0;
      hours       <= '0;
      minutes     <= '0;
      seconds     <= '0;
      secondTick  <= 1'b0;
      minuteTick  <= 1'b0;
      dayRollover <= 1'b0;
      loadError   <= 1'b0;
    end else begin
      secondTick  <= 1'b0;
      minuteTick  <= 1'b0;
      dayRollover <= 1'b0;
      if (update) begin
        hours     <= hours_bad ? '0 : setHours;
        minutes   <= minutes_bad ? '0 : setMinutes;
        seconds   <= seconds_bad ? '0 : setSeconds;
        prescaler <= '0;
        loadError <= loadError | hours_bad | minutes_bad | seconds_bad;
      end else if (!hold) begin
        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
        if (tick) begin
          seconds     <= sec_wrap ? '0 : seconds + 6'd1;
          minutes     <= sec_wrap ? (min_wrap ? '0 : minutes + 6'd1) : minutes;
          hours       <= (sec_wrap && min_wrap) ? (hr_wrap ? '0 : hours + 5'd1) : hours;
          secondTick  <= 1'b1;
          minuteTick  <= sec_wrap;
          dayRollover <= sec_wrap && min_wrap && hr_wrap;
        end
      end
    end
endmodule

// File: tb/tb_time_of_day_counter.sv
// tb_time_of_day_counter: directed bench for time_of_day_counter with CLK_FREQ=4
module tb_time_of_day_counter;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       update = 1'b0;
  logic       hold = 1'b0;
  logic [4:0] setHours = '0;
  logic [5:0] setMinutes = '0;
  logic [5:0] setSeconds = '0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       secondTick, minuteTick, dayRollover, loadError;
  int tests = 0;
  int fails = 0;
  time_of_day_counter #(.CLK_FREQ(4), .PRE_W(2)) dut (
    .clock(clock), .reset(reset), .update(update), .hold(hold),
    .setHours(setHours), .setMinutes(setMinutes), .setSeconds(setSeconds),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .secondTick(secondTick), .minuteTick(minuteTick),
    .dayRollover(dayRollover), .loadError(loadError)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    setHours = h;
    setMinutes = m;
    setSeconds = s;
    update = 1'b1;
    step();
    update = 1'b0;
  endtask
  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, ".h"}, 32'(hours), 32'(h));
    chk({tag, ".m"}, 32'(minutes), 32'(m));
    chk({tag, ".s"}, 32'(seconds), 32'(s));
  endtask
  initial begin
    #2 reset = 1'b0;
    #10;
    chk_time("rst", 0, 0, 0);
    chk("rst.stick", 32'(secondTick), 0);
    chk("rst.lerr", 32'(loadError), 0);
    @(negedge clock);
    reset = 1'b1;
    // 1: free run, tick every 4th edge
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("t1.stick", 32'(secondTick), 32'(i % 4 == 0));
      chk("t1.mtick", 32'(minuteTick), 0);
    end
    chk_time("t1", 0, 0, 4);
    // 2: seconds carry into minutes
    load(5'd0, 6'd0, 6'd58);
    chk_time("t2.load", 0, 0, 58);
    chk("t2.load.stick", 32'(secondTick), 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t2.stick", 32'(secondTick), 32'(i % 4 == 0));
      chk("t2.mtick", 32'(minuteTick), 32'(i == 8));
      if (i == 4) chk_time("t2.59", 0, 0, 59);
    end
    chk_time("t2.end", 0, 1, 0);
    // 3: day rollover
    load(5'd23, 6'd59, 6'd59);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t3.stick", 32'(secondTick), 32'(i == 4));
      chk("t3.mtick", 32'(minuteTick), 32'(i == 4));
      chk("t3.day", 32'(dayRollover), 32'(i == 4));
    end
    chk_time("t3", 0, 0, 0);
    step();
    chk("t3.day.off", 32'(dayRollover), 0);
    chk("t3.lerr", 32'(loadError), 0);
    // 4: out-of-range load
    load(5'd25, 6'd61, 6'd10);
    chk_time("t4.bad", 0, 0, 10);
    chk("t4.lerr", 32'(loadError), 1);
    load(5'd1, 6'd2, 6'd3);
    chk_time("t4.good", 1, 2, 3);
    chk("t4.lerr.sticky", 32'(loadError), 1);
    // 5: hold with prescaler at 2
    step();
    step();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5.hold.stick", 32'(secondTick), 0);
      chk("t5.hold.s", 32'(seconds), 3);
    end
    hold = 1'b0;
    step();
    chk("t5.rel1.stick", 32'(secondTick), 0);
    step();
    chk("t5.rel2.stick", 32'(secondTick), 1);
    chk_time("t5", 1, 2, 4);
    // 6: load on terminal count, then async reset
    step();
    step();
    step();
    load(5'd10, 6'd20, 6'd30);
    chk("t6.load.stick", 32'(secondTick), 0);
    chk_time("t6.load", 10, 20, 30);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t6.stick", 32'(secondTick), 32'(i == 4));
    end
    chk_time("t6.tick", 10, 20, 31);
    step();
    step();
    reset = 1'b0;
    #1;
    chk_time("t6.rst", 0, 0, 0);
    chk("t6.rst.lerr", 32'(loadError), 0);
    chk("t6.rst.stick", 32'(secondTick), 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t6.restart.stick", 32'(secondTick), 32'(i == 4));
    end
    chk_time("t6.restart", 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
